// File: rtl/jtag_debug_scan_master.sv
// jtag_debug_scan_master
//
// On-chip virtual-JTAG initiator. A management core hands over IR writes
// and DR scans on a valid/ready command channel. This block generates
// TCK, walks the debug module through its virtual states and returns the
// captured data on a valid/ready response channel.
//
// Ports
//   clk, reset              system clock, async active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_is_ir               1 = IR write, 0 = DR scan
//   cmd_len                 DR length; 0 or > DR_WIDTH means DR_WIDTH
//   cmd_data                IR value in [IR_WIDTH-1:0], or DR data, LSB first
//   resp_valid/resp_ready   response handshake, response held until taken
//   resp_data               DR capture right-justified, or ir_out zero-extended
//   tck, tdi, tdo           serial test clock and data
//   ir_in, ir_out           virtual IR value and responder IR status
//   vs_uir/vs_cdr/vs_sdr/vs_udr/rti   virtual state strobes
//   scan_count              completed responses, saturating
//                           (present only with JTAG_DEBUG_SCAN_MASTER_COUNT_EN)
//
// State table
//   state   | meaning
//   IDLE    | waiting for a command, cmd_ready high
//   LAUNCH  | one clk after acceptance, TCK still low, no strobe
//   UIR     | update-IR, one TCK period, ir_out sampled on the rising edge
//   CDR     | capture-DR, one TCK period
//   SDR     | shift-DR, N TCK periods
//   UDR     | update-DR, one TCK period
//   RTI     | run-test-idle, one TCK period
//   RESP    | resp_valid high until resp_ready

module jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [5:0]          cmd_len,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DR_WIDTH-1:0] resp_data,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                rti
`ifdef JTAG_DEBUG_SCAN_MASTER_COUNT_EN
    ,
    output logic [15:0]         scan_count
`endif
);

    localparam int              DIV_W      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TCK_DIV - 1);
    localparam logic [5:0]      LEN_MAX    = 6'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic                is_ir_q;
    logic [5:0]          len_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] capture_q;
    logic [5:0]          bit_cnt;

    logic                busy;
    logic                tick;
    logic                tck_rise;
    logic                tck_fall;
    logic [5:0]          eff_len;
    logic [DR_WIDTH-1:0] dr_result;

    always_comb begin
        busy      = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                    (state == S_UDR) || (state == S_RTI);
        tick      = (div_cnt == '0);
        tck_rise  = busy && tick && !tck;
        tck_fall  = busy && tick && tck;
        eff_len   = ((cmd_len == 6'd0) || (cmd_len > LEN_MAX)) ? LEN_MAX : cmd_len;
        // Captured bits enter at the MSB, so the first bit of an N-bit scan
        // sits at DR_WIDTH-N; shifting right lands it at bit 0.
        dr_result = capture_q >> (LEN_MAX - len_q);
    end

    // Held low during reset so every output reads 0 while reset is asserted.
    assign cmd_ready = (state == S_IDLE) && !resp_valid && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            is_ir_q    <= 1'b0;
            len_q      <= '0;
            ir_q       <= '0;
            shift_q    <= '0;
            capture_q  <= '0;
            bit_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            tck        <= 1'b0;
            tdi        <= 1'b0;
            ir_in      <= '0;
            vs_uir     <= 1'b0;
            vs_cdr     <= 1'b0;
            vs_sdr     <= 1'b0;
            vs_udr     <= 1'b0;
            rti        <= 1'b0;
        end else begin
            // TCK divider: runs only while walking the virtual states.
            if (busy) begin
                if (tick) begin
                    div_cnt <= DIV_RELOAD;
                    tck     <= ~tck;
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid && !resp_valid) begin
                        is_ir_q   <= cmd_is_ir;
                        len_q     <= eff_len;
                        ir_q      <= cmd_data[IR_WIDTH-1:0];
                        shift_q   <= cmd_data;
                        capture_q <= '0;
                        state     <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    div_cnt <= DIV_RELOAD;
                    tck     <= 1'b0;
                    if (is_ir_q) begin
                        ir_in  <= ir_q;
                        vs_uir <= 1'b1;
                        state  <= S_UIR;
                    end else begin
                        vs_cdr <= 1'b1;
                        state  <= S_CDR;
                    end
                end

                S_UIR: begin
                    if (tck_rise) begin
                        resp_data <= DR_WIDTH'(ir_out);
                    end
                    if (tck_fall) begin
                        vs_uir <= 1'b0;
                        rti    <= 1'b1;
                        state  <= S_RTI;
                    end
                end

                S_CDR: begin
                    if (tck_fall) begin
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        tdi     <= shift_q[0];
                        bit_cnt <= len_q;
                        state   <= S_SDR;
                    end
                end

                S_SDR: begin
                    if (tck_rise) begin
                        capture_q <= {tdo, capture_q[DR_WIDTH-1:1]};
                        shift_q   <= shift_q >> 1;
                        bit_cnt   <= bit_cnt - 6'd1;
                    end
                    if (tck_fall) begin
                        if (bit_cnt == 6'd0) begin
                            vs_sdr <= 1'b0;
                            vs_udr <= 1'b1;
                            tdi    <= 1'b0;
                            state  <= S_UDR;
                        end else begin
                            tdi <= shift_q[0];
                        end
                    end
                end

                S_UDR: begin
                    if (tck_fall) begin
                        vs_udr <= 1'b0;
                        rti    <= 1'b1;
                        state  <= S_RTI;
                    end
                end

                S_RTI: begin
                    // The divider drops tck on this same edge, so it stays low in RESP.
                    if (tck_fall) begin
                        rti        <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!is_ir_q) begin
                            resp_data <= dr_result;
                        end
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JTAG_DEBUG_SCAN_MASTER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_count <= '0;
        end else if (resp_valid && resp_ready && (scan_count != 16'hFFFF)) begin
            scan_count <= scan_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
module tb_jtag_debug_scan_master;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int TD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_is_ir;
    logic [5:0]    cmd_len;
    logic [DW-1:0] cmd_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          tck;
    logic          tdi;
    logic          tdo;
    logic [IW-1:0] ir_in;
    logic [IW-1:0] ir_out;
    logic          vs_uir;
    logic          vs_cdr;
    logic          vs_sdr;
    logic          vs_udr;
    logic          rti;
`ifdef JTAG_DEBUG_SCAN_MASTER_COUNT_EN
    logic [15:0]   scan_count;
`endif

    jtag_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_is_ir  (cmd_is_ir),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .tck        (tck),
        .tdi        (tdi),
        .tdo        (tdo),
        .ir_in      (ir_in),
        .ir_out     (ir_out),
        .vs_uir     (vs_uir),
        .vs_cdr     (vs_cdr),
        .vs_sdr     (vs_sdr),
        .vs_udr     (vs_udr),
        .rti        (rti)
`ifdef JTAG_DEBUG_SCAN_MASTER_COUNT_EN
        ,
        .scan_count (scan_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: a DR_WIDTH shift register looped from tdi to tdo, shifting on
    // TCK rising edges while in shift-DR.
    logic [DW-1:0] rsp_reg = '0;
    logic [DW-1:0] rsp_preload = '0;
    logic          load_stb = 1'b0;
    int            sdr_edges = 0;
    assign tdo = rsp_reg[0];

    always @(posedge tck or posedge load_stb) begin
        if (load_stb) begin
            rsp_reg   <= rsp_preload;
            sdr_edges <= 0;
        end else if (vs_sdr) begin
            rsp_reg   <= {tdi, rsp_reg[DW-1:1]};
            sdr_edges <= sdr_edges + 1;
        end
    end

    logic [IW-1:0] ir_exp = '0;
    int uir_clks = 0;
    int ir_bad = 0;
    int tdi_bad = 0;
    int tck_toggles = 0;

    always @(negedge clk) begin
        if (vs_uir) begin
            uir_clks++;
            if (ir_in !== ir_exp) ir_bad++;
        end
        if (tdi && !vs_sdr) tdi_bad++;
    end

    always @(posedge tck or negedge tck) tck_toggles++;

    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [DW-1:0] v);
        rsp_preload = v;
        load_stb = 1'b1;
        #1;
        load_stb = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit is_ir, input logic [5:0] len, input logic [DW-1:0] data,
                        input logic [DW-1:0] exp_resp, input bit push);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_is_ir = is_ir;
        cmd_len   = len;
        cmd_data  = data;
        acc_cyc   = cyc + 1;
        if (push) exp_q.push_back(exp_resp);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic wait_resp(input string tag, input int lat, input bit take);
        int n;
        logic [DW-1:0] e;
        n = 0;
        while (!resp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_resp"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, resp_data, e);
        end
        if (take) begin
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    initial begin : main
        int u0, b0, t0, tk0, n;
        int stable_bad, rdy_bad, valid_bad, late_valid;
        logic [DW-1:0] snap, rnd;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_is_ir = 1'b0;
        cmd_len = '0;
        cmd_data = '0;
        resp_ready = 1'b0;
        ir_out = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti, resp_valid, cmd_ready}, 0);
        chk("reset_resp_data", resp_data, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_valid", resp_valid, 0);

        // IR write
        t0 = tdi_bad;
        ir_out = 2'b01;
        ir_exp = 2'b10;
        u0 = uir_clks;
        b0 = ir_bad;
        send(1'b1, 6'd0, 38'h2, 38'h1, 1'b1);
        wait_resp("ir", 1 + 2 * (2 * TD), 1'b1);
        chk("ir_uir_clks", 64'(uir_clks - u0), 4);
        chk("ir_in_during_uir", 64'(ir_bad - b0), 0);
        chk("ir_in_held", ir_in, 2'b10);

        // DR 38 loopback
        preload(38'h15_1234_5678);
        send(1'b0, 6'd38, 38'h2A_5A5A_5A5A, 38'h15_1234_5678, 1'b1);
        wait_resp("dr38", 1 + (38 + 3) * (2 * TD), 1'b1);
        chk("dr38_responder", rsp_reg, 38'h2A_5A5A_5A5A);
        chk("dr38_sdr_edges", 64'(sdr_edges), 38);

        // DR 8, tdo stream 1,0,1,1,0,0,0,1
        preload(38'h8D);
        send(1'b0, 6'd8, 38'h3C, 38'h8D, 1'b1);
        wait_resp("dr8", 1 + 11 * (2 * TD), 1'b1);
        chk("dr8_sdr_edges", 64'(sdr_edges), 8);
        chk("dr8_responder", rsp_reg, {8'h3C, 30'd0});

        // length 0 and length above DR_WIDTH both mean a full scan
        preload(38'h2B_CDEF_0123);
        send(1'b0, 6'd0, 38'h0, 38'h2B_CDEF_0123, 1'b1);
        wait_resp("len0", 1 + 41 * (2 * TD), 1'b1);
        chk("len0_sdr_edges", 64'(sdr_edges), 38);
        rnd = {$urandom(), $urandom()};
        preload(rnd);
        send(1'b0, 6'd45, 38'h1F, rnd, 1'b1);
        wait_resp("len45", 1 + 41 * (2 * TD), 1'b1);
        chk("len45_sdr_edges", 64'(sdr_edges), 38);
        chk("tdi_low_outside_sdr", 64'(tdi_bad - t0), 0);

        // Response back-pressure with a command already waiting
        preload(38'h3A);
        send(1'b0, 6'd4, 38'h5, 38'hA, 1'b1);
        wait_resp("stall_dr", 1 + 7 * (2 * TD), 1'b0);
        ir_out = 2'b11;
        ir_exp = 2'b01;
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b1;
        cmd_len = 6'd0;
        cmd_data = 38'h1;
        snap = resp_data;
        tk0 = tck_toggles;
        stable_bad = 0;
        rdy_bad = 0;
        valid_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_data !== snap) stable_bad++;
            if (cmd_ready) rdy_bad++;
            if (!resp_valid) valid_bad++;
        end
        chk("stall_data_stable", 64'(stable_bad), 0);
        chk("stall_cmd_ready_low", 64'(rdy_bad), 0);
        chk("stall_valid_held", 64'(valid_bad), 0);
        chk("stall_no_tck", 64'(tck_toggles - tk0), 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_take", cmd_ready, 1);
        acc_cyc = cyc + 1;
        exp_q.push_back(38'h3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("next_cmd_accepted", cmd_ready, 0);
        wait_resp("stall_ir", 1 + 2 * (2 * TD), 1'b1);

        // Reset in the middle of shift-DR
        preload(38'h0);
        send(1'b0, 6'd38, 38'h3F_FFFF_FFFF, 38'h0, 1'b0);
        n = 0;
        while (sdr_edges < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midscan_reached_sdr", 64'(sdr_edges >= 10), 1);
        reset = 1'b1;
        #1;
        chk("midscan_reset_outputs", {tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti, resp_valid, cmd_ready}, 0);
        chk("midscan_reset_resp_data", resp_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midscan_ready", cmd_ready, 1);
        late_valid = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) late_valid++;
        end
        chk("midscan_no_resp", 64'(late_valid), 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
